// File: rtl/iter_alu_n.sv
// Iterative integer execute unit: single-cycle ALU/branch ops, multi-cycle shifts
// (up to SHIFT_STEP bits per cycle) and an optional shift-add multiplier.
module iter_alu_n #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int MUL_EN     = 1,
    parameter int MUL_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [XLEN-1:0]         src_a,
    input  logic [XLEN-1:0]         src_b,
    input  logic [2:0]              f3,
    input  logic                    arith_bit,
    input  logic                    branch,
    input  logic                    mul,
    output logic [XLEN-1:0]         out,
    output logic [XLEN-1:0]         adder_out,
    output logic                    cond,
    output logic [$clog2(XLEN)-1:0] shamt_out,
    output logic                    busy,
    output logic                    done
);
    localparam int LW = $clog2(XLEN);
    localparam int DW = 2 * XLEN;
    localparam int MN = XLEN / MUL_BITS;
    localparam int CW = $clog2(MN + 1);
    localparam logic [LW:0]     STEP_MAX = (LW+1)'(SHIFT_STEP);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MN);
    localparam logic [XLEN-1:0] ONES     = '1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

    // Handshake: start is taken only in a cycle with busy=0 and rst=0; done
    // pulses for exactly one cycle with the result on out. start while busy,
    // including the done cycle of an iterative op, is dropped.
    state_t            state;
    logic [XLEN-1:0]   res_q, sh_q, mb_q;
    logic [LW-1:0]     rem_q;
    logic              sign_q, left_q, arith_q, iter_done_q;
    logic [DW-1:0]     acc_q, ma_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, mhi_q, mzero_q;

    logic              accept, is_shift, go_shift, go_mul, single, use_sub;
    logic              lt_s, lt_u, eq, br_cmp;
    logic [XLEN-1:0]   alu_res, sh_src, sh_next, mul_res, abs_a, abs_b, m_b;
    logic [LW-1:0]     sh_rem, rem_next;
    logic [LW:0]       step;
    logic              sh_sign, sh_left, sh_arith, a_sgn, b_sgn;
    logic [DW-1:0]     m_a, m_acc, acc_next, prod_fix;
    logic [CW-1:0]     cnt_next;

    assign busy     = (state != S_IDLE);
    assign accept   = start & ~busy & ~rst;
    assign is_shift = ~branch & ~mul & (f3[1:0] == 2'b01);
    assign go_shift = accept & is_shift & (src_b[LW-1:0] != '0);
    assign go_mul   = accept & mul & (MUL_EN != 0);
    assign single   = accept & ~go_shift & ~go_mul;

    assign use_sub   = branch | (arith_bit & ~mul & (f3 == 3'b000));
    assign adder_out = use_sub ? (src_a - src_b) : (src_a + src_b);
    assign lt_s      = $signed(src_a) < $signed(src_b);
    assign lt_u      = src_a < src_b;
    assign eq        = src_a == src_b;

    always_comb begin
        br_cmp = 1'b0;
        case (f3)
            3'b000:  br_cmp = eq;
            3'b001:  br_cmp = ~eq;
            3'b100:  br_cmp = lt_s;
            3'b101:  br_cmp = ~lt_s;
            3'b110:  br_cmp = lt_u;
            3'b111:  br_cmp = ~lt_u;
            default: br_cmp = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        if (branch) begin
            alu_res = {{(XLEN-1){1'b0}}, br_cmp};
        end else if (!mul) begin
            case (f3)
                3'b000:  alu_res = adder_out;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
                3'b100:  alu_res = src_a ^ src_b;
                3'b110:  alu_res = src_a | src_b;
                3'b111:  alu_res = src_a & src_b;
                default: alu_res = src_a;  // zero-distance shift
            endcase
        end
    end

    // Shift step shared by the start edge (live operands) and SHIFT (latched state).
    always_comb begin
        sh_src   = busy ? sh_q    : src_a;
        sh_rem   = busy ? rem_q   : src_b[LW-1:0];
        sh_sign  = busy ? sign_q  : src_a[XLEN-1];
        sh_left  = busy ? left_q  : (f3 == 3'b001);
        sh_arith = busy ? arith_q : (arith_bit & (f3 == 3'b101));
        step     = ({1'b0, sh_rem} > STEP_MAX) ? STEP_MAX : {1'b0, sh_rem};
        rem_next = sh_rem - step[LW-1:0];
        if (sh_left)
            sh_next = sh_src << step;
        else
            sh_next = (sh_src >> step) | ((sh_arith & sh_sign) ? ~(ONES >> step) : '0);
    end

    // Multiplier works on magnitudes; the sign is restored after the last step.
    always_comb begin
        a_sgn    = src_a[XLEN-1] & ((f3[1:0] == 2'b01) | (f3[1:0] == 2'b10));
        b_sgn    = src_b[XLEN-1] & (f3[1:0] == 2'b01);
        abs_a    = a_sgn ? -src_a : src_a;
        abs_b    = b_sgn ? -src_b : src_b;
        m_a      = busy ? ma_q  : {{XLEN{1'b0}}, abs_a};
        m_b      = busy ? mb_q  : abs_b;
        m_acc    = busy ? acc_q : '0;
        acc_next = m_acc + m_a * DW'(m_b[MUL_BITS-1:0]);
        cnt_next = (busy ? cnt_q : '0) + 1'b1;
        prod_fix = neg_q ? -acc_q : acc_q;
        mul_res  = mzero_q ? '0 : (mhi_q ? prod_fix[DW-1:XLEN] : prod_fix[XLEN-1:0]);
    end

    assign done      = single | iter_done_q;
    assign cond      = single & branch & br_cmp;
    assign shamt_out = (state == S_SHIFT) ? rem_q : '0;
    assign out       = single ? alu_res :
                       ((state == S_MUL) && iter_done_q) ? mul_res : res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            res_q       <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
            iter_done_q <= 1'b0;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            mhi_q       <= 1'b0;
            mzero_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (single)
                        res_q <= alu_res;
                    if (go_shift) begin
                        state       <= S_SHIFT;
                        sh_q        <= sh_next;
                        rem_q       <= rem_next;
                        sign_q      <= src_a[XLEN-1];
                        left_q      <= sh_left;
                        arith_q     <= sh_arith;
                        iter_done_q <= (rem_next == '0);
                        if (rem_next == '0)
                            res_q <= sh_next;
                    end
                    if (go_mul) begin
                        state       <= S_MUL;
                        acc_q       <= acc_next;
                        ma_q        <= m_a << MUL_BITS;
                        mb_q        <= m_b >> MUL_BITS;
                        cnt_q       <= cnt_next;
                        iter_done_q <= (cnt_next == CNT_LAST);
                        neg_q       <= a_sgn ^ b_sgn;
                        mhi_q       <= (f3[1:0] != 2'b00);
                        mzero_q     <= f3[2];
                    end
                end
                S_SHIFT: begin
                    if (iter_done_q) begin
                        state       <= S_IDLE;
                        iter_done_q <= 1'b0;
                    end else begin
                        sh_q  <= sh_next;
                        rem_q <= rem_next;
                        if (rem_next == '0) begin
                            iter_done_q <= 1'b1;
                            res_q       <= sh_next;
                        end
                    end
                end
                S_MUL: begin
                    if (iter_done_q) begin
                        state       <= S_IDLE;
                        iter_done_q <= 1'b0;
                        res_q       <= mul_res;
                    end else begin
                        acc_q       <= acc_next;
                        ma_q        <= m_a << MUL_BITS;
                        mb_q        <= m_b >> MUL_BITS;
                        cnt_q       <= cnt_next;
                        iter_done_q <= (cnt_next == CNT_LAST);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
